// File: rtl/pkt_slot_manager.sv
// Free-slot allocator for the cut / no-cut packet buffers, round-robin per pool.
// Latency: grant/fail and dbl_free_err are registered, 1 cycle after the request/strobe.
// Backpressure: none; a request to an exhausted pool returns a one-cycle alloc_fail pulse.

// One pool: free bitmap, last-granted pointer, free counter and registered empty flag.
module pkt_slot_pool #(
    parameter int SLOT_BITS = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req,
    input  logic                 rec_wr,
    input  logic [SLOT_BITS-1:0] rec_addr,
    output logic                 found,
    output logic [SLOT_BITS-1:0] slot,
    output logic                 dbl,
    output logic [SLOT_BITS:0]   free_cnt,
    output logic                 empty
);
    localparam int NSLOT = 1 << SLOT_BITS;
    localparam int CW    = SLOT_BITS + 1;

    logic [NSLOT-1:0]     bitmap;
    logic [SLOT_BITS-1:0] lp;
    logic [SLOT_BITS-1:0] idx;
    logic [NSLOT-1:0]     map_nxt;
    logic [CW-1:0]        cnt_nxt;
    logic                 hit;
    logic                 rec_ok;
    logic                 take;

    // Round-robin search of the registered bitmap starting just after the last grant.
    // The final iteration wraps back onto lp itself, so every slot is covered.
    always_comb begin
        found = 1'b0;
        slot  = '0;
        idx   = '0;
        for (int i = 1; i <= NSLOT; i++) begin
            idx = lp + SLOT_BITS'(i);
            if (!found && bitmap[idx]) begin
                found = 1'b1;
                slot  = idx;
            end
        end
    end

    // A recycle of an already-free slot is ignored and flagged. This also covers
    // recycling the slot being granted this cycle, since that slot is free pre-edge.
    assign hit    = bitmap[rec_addr];
    assign rec_ok = rec_wr && !hit;
    assign dbl    = rec_wr && hit;
    assign take   = req && found;

    // Next bitmap and counter; a successful recycle and a grant can never hit the same bit.
    always_comb begin
        map_nxt = bitmap;
        if (rec_ok) begin
            map_nxt[rec_addr] = 1'b1;
        end
        if (take) begin
            map_nxt[slot] = 1'b0;
        end
        cnt_nxt = free_cnt + CW'(rec_ok) - CW'(take);
    end

    // Pool state; lp resets to all ones so the first grant lands on slot 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            bitmap   <= '1;
            lp       <= '1;
            free_cnt <= CW'(NSLOT);
            empty    <= 1'b0;
        end else begin
            bitmap   <= map_nxt;
            free_cnt <= cnt_nxt;
            empty    <= (cnt_nxt == '0);
            if (take) begin
                lp <= slot;
            end
        end
    end
endmodule

module pkt_slot_manager #(
    parameter int SLOT_BITS = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   alloc_req,
    input  logic                   alloc_cut,
    output logic                   alloc_grant,
    output logic [SLOT_BITS:0]     alloc_addr,
    output logic [SLOT_BITS+6:0]   alloc_ram_base,
    output logic                   alloc_fail,
    input  logic [SLOT_BITS-1:0]   cut_recycle_addr,
    input  logic                   cut_recycle_wr,
    input  logic [SLOT_BITS-1:0]   nocut_recycle_addr,
    input  logic                   nocut_recycle_wr,
    output logic [SLOT_BITS:0]     cut_free_cnt,
    output logic [SLOT_BITS:0]     nocut_free_cnt,
    output logic                   cut_empty,
    output logic                   nocut_empty,
    output logic                   dbl_free_err
);
    logic                 cut_found;
    logic                 nocut_found;
    logic [SLOT_BITS-1:0] cut_slot;
    logic [SLOT_BITS-1:0] nocut_slot;
    logic                 cut_dbl;
    logic                 nocut_dbl;
    logic                 sel_found;
    logic [SLOT_BITS-1:0] sel_slot;

    pkt_slot_pool #(.SLOT_BITS(SLOT_BITS)) u_cut (
        .clk      (clk),
        .reset    (reset),
        .req      (alloc_req && alloc_cut),
        .rec_wr   (cut_recycle_wr),
        .rec_addr (cut_recycle_addr),
        .found    (cut_found),
        .slot     (cut_slot),
        .dbl      (cut_dbl),
        .free_cnt (cut_free_cnt),
        .empty    (cut_empty)
    );

    pkt_slot_pool #(.SLOT_BITS(SLOT_BITS)) u_nocut (
        .clk      (clk),
        .reset    (reset),
        .req      (alloc_req && !alloc_cut),
        .rec_wr   (nocut_recycle_wr),
        .rec_addr (nocut_recycle_addr),
        .found    (nocut_found),
        .slot     (nocut_slot),
        .dbl      (nocut_dbl),
        .free_cnt (nocut_free_cnt),
        .empty    (nocut_empty)
    );

    assign sel_found = alloc_cut ? cut_found : nocut_found;
    assign sel_slot  = alloc_cut ? cut_slot  : nocut_slot;

    // Registered response; address outputs hold the last grant between grants.
    always_ff @(posedge clk) begin
        if (reset) begin
            alloc_grant    <= 1'b0;
            alloc_fail     <= 1'b0;
            alloc_addr     <= '0;
            alloc_ram_base <= '0;
            dbl_free_err   <= 1'b0;
        end else begin
            alloc_grant  <= alloc_req && sel_found;
            alloc_fail   <= alloc_req && !sel_found;
            dbl_free_err <= cut_dbl || nocut_dbl;
            if (alloc_req && sel_found) begin
                alloc_addr     <= {alloc_cut, sel_slot};
                alloc_ram_base <= {sel_slot, 7'b0};
            end
        end
    end
endmodule

// File: tb/tb_pkt_slot_manager.sv
// Bench for pkt_slot_manager: directed stimulus, expected responses queued at issue time.
// Latency: responses are expected at the negedge following the sampling edge.
// Backpressure: none; a monitor pops the queues whenever the DUT pulses an output.
module tb_pkt_slot_manager;
    localparam int SB = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          alloc_req;
    logic          alloc_cut;
    logic          alloc_grant;
    logic [SB:0]   alloc_addr;
    logic [SB+6:0] alloc_ram_base;
    logic          alloc_fail;
    logic [SB-1:0] cut_recycle_addr;
    logic          cut_recycle_wr;
    logic [SB-1:0] nocut_recycle_addr;
    logic          nocut_recycle_wr;
    logic [SB:0]   cut_free_cnt;
    logic [SB:0]   nocut_free_cnt;
    logic          cut_empty;
    logic          nocut_empty;
    logic          dbl_free_err;

    pkt_slot_manager #(.SLOT_BITS(SB)) dut (
        .clk                (clk),
        .reset              (reset),
        .alloc_req          (alloc_req),
        .alloc_cut          (alloc_cut),
        .alloc_grant        (alloc_grant),
        .alloc_addr         (alloc_addr),
        .alloc_ram_base     (alloc_ram_base),
        .alloc_fail         (alloc_fail),
        .cut_recycle_addr   (cut_recycle_addr),
        .cut_recycle_wr     (cut_recycle_wr),
        .nocut_recycle_addr (nocut_recycle_addr),
        .nocut_recycle_wr   (nocut_recycle_wr),
        .cut_free_cnt       (cut_free_cnt),
        .nocut_free_cnt     (nocut_free_cnt),
        .cut_empty          (cut_empty),
        .nocut_empty        (nocut_empty),
        .dbl_free_err       (dbl_free_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic       fail;
        logic [4:0] addr;
        int         at;
    } resp_t;

    resp_t resp_q[$];
    int    err_q[$];
    int    errors = 0;
    int    checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pop an expectation whenever the DUT pulses grant/fail or a double-free error.
    resp_t r;
    int    e;
    always @(negedge clk) begin
        if (alloc_grant || alloc_fail) begin
            if (resp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_response: grant=%0b fail=%0b addr=0x%0h, none expected (cycle %0d)",
                         alloc_grant, alloc_fail, alloc_addr, cyc);
            end else begin
                r = resp_q.pop_front();
                chk("resp_cycle", cyc, r.at);
                chk("resp_fail", alloc_fail, r.fail);
                chk("resp_grant", alloc_grant, !r.fail);
                if (!r.fail) begin
                    chk("alloc_addr", alloc_addr, r.addr);
                    chk("alloc_ram_base", alloc_ram_base, {r.addr[3:0], 7'b0});
                end
            end
        end
        if (dbl_free_err) begin
            if (err_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_dbl_free_err: got 1 expected 0 (cycle %0d)", cyc);
            end else begin
                e = err_q.pop_front();
                chk("dbl_err_cycle", cyc, e);
            end
        end
    end

    task automatic exp_grant(input logic [4:0] a);
        resp_q.push_back('{1'b0, a, cyc + 1});
    endtask

    task automatic exp_fail();
        resp_q.push_back('{1'b1, 5'd0, cyc + 1});
    endtask

    task automatic exp_err();
        err_q.push_back(cyc + 1);
    endtask

    // Apply one cycle of inputs, return 1 time unit after the sampling edge.
    task automatic step(input logic req, input logic cut,
                        input logic cwr, input logic [3:0] ca,
                        input logic nwr, input logic [3:0] na);
        alloc_req          = req;
        alloc_cut          = cut;
        cut_recycle_wr     = cwr;
        cut_recycle_addr   = ca;
        nocut_recycle_wr   = nwr;
        nocut_recycle_addr = na;
        @(posedge clk);
        #1;
        alloc_req        = 1'b0;
        cut_recycle_wr   = 1'b0;
        nocut_recycle_wr = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        reset = 1'b0;
    endtask

    initial begin
        reset              = 1'b1;
        alloc_req          = 1'b0;
        alloc_cut          = 1'b0;
        cut_recycle_wr     = 1'b0;
        cut_recycle_addr   = '0;
        nocut_recycle_wr   = 1'b0;
        nocut_recycle_addr = '0;
        @(posedge clk);
        #1;
        do_reset();

        // Reset state
        chk("rst_grant", alloc_grant, 0);
        chk("rst_fail", alloc_fail, 0);
        chk("rst_dbl", dbl_free_err, 0);
        chk("rst_addr", alloc_addr, 0);
        chk("rst_ram_base", alloc_ram_base, 0);
        chk("rst_cut_cnt", cut_free_cnt, 16);
        chk("rst_nocut_cnt", nocut_free_cnt, 16);
        chk("rst_cut_empty", cut_empty, 0);
        chk("rst_nocut_empty", nocut_empty, 0);

        // Drain the cut pool with 16 back-to-back requests, then one that must fail
        for (int i = 0; i < 16; i++) begin
            exp_grant({1'b1, 4'(i)});
            step(1, 1, 0, 0, 0, 0);
            chk("fill_cut_cnt", cut_free_cnt, 15 - i);
        end
        chk("fill_cut_empty", cut_empty, 1);
        exp_fail();
        step(1, 1, 0, 0, 0, 0);
        chk("fail_cut_cnt", cut_free_cnt, 0);
        chk("hold_addr", alloc_addr, 5'h1F);
        chk("hold_ram_base", alloc_ram_base, 11'h780);

        // Recycle slot 5 with a same-cycle request (fails), then request next cycle
        exp_fail();
        step(1, 1, 1, 5, 0, 0);
        chk("rec5_cut_cnt", cut_free_cnt, 1);
        chk("rec5_cut_empty", cut_empty, 0);
        exp_grant(5'h15);
        step(1, 1, 0, 0, 0, 0);
        chk("grant5_cut_cnt", cut_free_cnt, 0);
        chk("grant5_cut_empty", cut_empty, 1);

        // Round-robin: grant 0,1,2; recycle 0; next grants 3..15 then wrap to 0
        do_reset();
        for (int i = 0; i < 3; i++) begin
            exp_grant(5'h10 + 5'(i));
            step(1, 1, 0, 0, 0, 0);
        end
        step(0, 1, 1, 0, 0, 0);
        chk("rr_rec0_cnt", cut_free_cnt, 14);
        for (int i = 3; i < 16; i++) begin
            exp_grant(5'h10 + 5'(i));
            step(1, 1, 0, 0, 0, 0);
        end
        chk("rr_cnt_before_wrap", cut_free_cnt, 1);
        exp_grant(5'h10);
        step(1, 1, 0, 0, 0, 0);
        chk("rr_wrap_cnt", cut_free_cnt, 0);
        chk("rr_wrap_empty", cut_empty, 1);

        // Double free on the no-cut pool (slot 7 is free) and on the cut pool (slot 9 twice)
        exp_err();
        step(0, 0, 0, 0, 1, 7);
        chk("dbl_nocut_cnt", nocut_free_cnt, 16);
        step(0, 0, 1, 9, 0, 0);
        chk("rec9_cut_cnt", cut_free_cnt, 1);
        exp_err();
        step(0, 0, 1, 9, 0, 0);
        chk("dbl_cut_cnt", cut_free_cnt, 1);

        // Simultaneous cut recycle, no-cut recycle and no-cut grant
        exp_grant(5'h00);
        step(1, 0, 0, 0, 0, 0);
        chk("nocut_grant0_cnt", nocut_free_cnt, 15);
        exp_grant(5'h01);
        step(1, 0, 1, 3, 1, 0);
        chk("sim_cut_cnt", cut_free_cnt, 2);
        chk("sim_nocut_cnt", nocut_free_cnt, 15);
        chk("sim_cut_empty", cut_empty, 0);

        // Reset mid-stream with 9 cut slots allocated; the request at the reset edge is dropped
        do_reset();
        for (int i = 0; i < 9; i++) begin
            exp_grant(5'h10 + 5'(i));
            step(1, 1, 0, 0, 0, 0);
        end
        chk("mid_cut_cnt", cut_free_cnt, 7);
        reset = 1'b1;
        step(1, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        chk("mid_rst_cut_cnt", cut_free_cnt, 16);
        chk("mid_rst_nocut_cnt", nocut_free_cnt, 16);
        chk("mid_rst_cut_empty", cut_empty, 0);
        chk("mid_rst_nocut_empty", nocut_empty, 0);
        chk("mid_rst_grant", alloc_grant, 0);
        exp_grant(5'h10);
        step(1, 1, 0, 0, 0, 0);
        chk("post_rst_cut_cnt", cut_free_cnt, 15);

        // Let the monitor consume the last responses, then confirm nothing is missing
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("resp_q_drained", resp_q.size(), 0);
        chk("err_q_drained", err_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
